csr_timer_array: RTL and testbench
==================================

# csr_timer_array

Parametrised multi-channel timer/interrupt block for the CSR unit. It replaces the single TCFG/TVAL/TICLR timer and the free-running 64-bit stable counter. Each of NUM_TIMERS channels has:
- a programmable down-counter;
- one-shot or periodic mode;
- a sticky pending bit with software clear.

Pending bits are masked and OR-reduced into one timer interrupt line, which feeds ESTAT.IS_TI. The block sits beside the CSR register file and shares its write strobe timing.

## Interface
Parameters:
- NUM_TIMERS, 4, number of timer channels (1..64)
- TW, 32, timer value width (≥ 4)
- CNT_W, 64, stable counter width
- PRESCALE, 16, decrement interval in cycles (≥ 2). Used only when TIMER_PRESCALE_EN is defined.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wen  in  1  register write strobe
- waddr  in  8  write address: [7:2] channel, [1:0] register
- wdata  in  TW  write data
- raddr  in  8  read address, same encoding as waddr
- rdata  out  TW  combinational read data
- irq_mask  in  NUM_TIMERS  per-channel interrupt enable
- ie  in  1  global interrupt enable (CRMD.IE)
- pending  out  NUM_TIMERS  per-channel pending bits
- irq_out  out  1  equals |(pending & irq_mask) & ie
- stable_cnt  out  CNT_W  free-running counter

## Operation
Register map per channel (waddr[1:0]):
- 0 TCFG (read/write): bit0 En, bit1 Periodic, [TW-1:2] InitVal.
- 1 TVAL (read-only): current count.
- 2 TICLR (write-only): writing bit0=1 clears pending. Reads return 0.
- 3 STATUS (read-only): {TW-2 zeros, pending, run}.

Channel state: tcfg, tval, run, pend.

Address decoding:
- A channel index ≥ NUM_TIMERS: write ignored, read returns 0.
- A write to TVAL or STATUS is ignored.

TCFG write:
- tcfg <= wdata.
- tval <= {wdata[TW-1:2], 2'b00}.
- run <= wdata[0].

Count step (run=1, no TCFG write to this channel, tick=1):
- tval≠0: tval <= tval−1.
- tval=0 (expiry):
  - pend <= 1.
  - Periodic=1: tval <= {InitVal, 2'b00}, run stays 1.
  - Periodic=0: tval stays 0 and run <= 0. tcfg.En keeps its written value.

run=0: tval holds its value.

Pending priority:
- Expiry set wins over a same-cycle TICLR clear.
- Expiry is evaluated on pre-edge state. A TCFG write in the expiry cycle still sets pend, but tval/run take the written values.

Other behaviour:
- stable_cnt increments every cycle and wraps from all-ones to 0.
- Channels are fully independent. One write affects at most one channel.

## Timing
Reset values: tcfg, tval, run, pend, stable_cnt, pending and irq_out are all 0. rdata is 0 for every in-range address.

Latencies:
- Write at edge k is visible on rdata after edge k.
- irq_out is combinational from pending, irq_mask and ie. It has zero cycles of latency from a pending change.

Expiry timing, without prescale:
- TCFG write with InitVal field value V (tval = 4V) at edge 0.
- tval reaches 0 after edge 4V.
- pend rises after edge 4V+1.
- Periodic period is 4V+1 cycles.
- InitVal=0 expires on edge 1.

Prescale: tick is a shared free-running counter, 1 for one cycle every PRESCALE cycles. All channel steps, including the expiry step, occur only on tick cycles.

Reset mid-count: rst overrides all writes and count steps in the same edge.

## Configuration
Macro TIMER_PRESCALE_EN:
- Defined: a log2(PRESCALE)-bit prescale counter generates tick as above. The counter resets to 0; tick is asserted when the counter equals PRESCALE−1, after which it wraps to 0. The first tick comes PRESCALE cycles after reset.
- Undefined: tick is constant 1, no prescale logic is generated, and PRESCALE is ignored.

stable_cnt never uses tick.

## Test plan
- Reset, then read all addresses: rdata=0, irq_out=0. stable_cnt reads 5 after 5 cycles post-reset.
- One-shot, ch1, no prescale: TCFG=0x0000_0011 (En, InitVal=4, tval=16). pending[1] rises exactly 17 cycles after the write edge, and run=0 afterwards. With irq_mask=0b0010 and ie=1, irq_out=1. TICLR=1 drops pending[1] and irq_out next cycle.
- Periodic, ch0: TCFG=0x0000_0007 (tval=4). pending[0] is re-set every 5 cycles. A TICLR written on an expiry cycle leaves pending[0]=1.
- Independence/range: ch2 and ch3 run with different InitVals. With NUM_TIMERS=4, writes to channel index 5 are ignored and reads of it return 0. With ie=0, irq_out stays 0 despite pending.
- Edge cases:
  - TCFG rewrite mid-count reloads tval.
  - TCFG with En=0 freezes tval at its loaded value.
  - rst asserted mid-count zeroes all state on the same edge.
  - stable_cnt forced near wrap (CNT_W=8) wraps 0xFF→0x00.
- With TIMER_PRESCALE_EN and PRESCALE=4: TCFG=0x5 (tval=4) expires after 5 ticks (~20 cycles), and tval decrements only on tick cycles.

Source files
------------

// File: rtl/csr_timer_array_if.sv
// Register-bus and interrupt signal bundle for csr_timer_array.
// master = CSR unit side, slave = timer block side.
interface csr_timer_array_if #(
    parameter int unsigned NUM_TIMERS = 4,
    parameter int unsigned TW         = 32,
    parameter int unsigned CNT_W      = 64
);
    logic                  wen;
    logic [7:0]            waddr;
    logic [TW-1:0]         wdata;
    logic [7:0]            raddr;
    logic [TW-1:0]         rdata;
    logic [NUM_TIMERS-1:0] irq_mask;
    logic                  ie;
    logic [NUM_TIMERS-1:0] pending;
    logic                  irq_out;
    logic [CNT_W-1:0]      stable_cnt;

    modport master (
        output wen, waddr, wdata, raddr, irq_mask, ie,
        input  rdata, pending, irq_out, stable_cnt
    );

    modport slave (
        input  wen, waddr, wdata, raddr, irq_mask, ie,
        output rdata, pending, irq_out, stable_cnt
    );
endinterface

// File: rtl/csr_timer_array.sv
// Multi-channel down-counting timer array with sticky pending bits, masked IRQ and stable counter.
// Optional shared tick prescaler enabled by defining TIMER_PRESCALE_EN.
module csr_timer_array #(
    parameter int unsigned NUM_TIMERS = 4,
    parameter int unsigned TW         = 32,
    parameter int unsigned CNT_W      = 64,
    parameter int unsigned PRESCALE   = 16
) (
    input logic              clk,
    input logic              rst,
    csr_timer_array_if.slave bus
);
    typedef enum logic [1:0] {
        REG_TCFG   = 2'd0,
        REG_TVAL   = 2'd1,
        REG_TICLR  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    if (NUM_TIMERS < 1 || NUM_TIMERS > 64 || TW < 4 || PRESCALE < 2) begin : g_bad_params
        $error("csr_timer_array: parameter out of range");
    end

    logic [TW-1:0]         r_tcfg [NUM_TIMERS];
    logic [TW-1:0]         r_tval [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] r_run;
    logic [NUM_TIMERS-1:0] r_pend;
    logic [CNT_W-1:0]      r_stable;

    logic                  w_tick;
    logic [5:0]            w_wch;
    logic [5:0]            w_rch;
    reg_e                  w_wreg;
    reg_e                  w_rreg;
    logic                  w_wvalid;
    logic                  w_rvalid;
    logic [NUM_TIMERS-1:0] w_cfg_wr;
    logic [NUM_TIMERS-1:0] w_clr;
    logic [NUM_TIMERS-1:0] w_expire;
    logic [TW-1:0]         w_rdata;

    assign w_wch    = bus.waddr[7:2];
    assign w_rch    = bus.raddr[7:2];
    assign w_wreg   = reg_e'(bus.waddr[1:0]);
    assign w_rreg   = reg_e'(bus.raddr[1:0]);
    assign w_wvalid = bus.wen && (32'(w_wch) < NUM_TIMERS);
    assign w_rvalid = 32'(w_rch) < NUM_TIMERS;

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned PW = $clog2(PRESCALE);
    logic [PW-1:0] r_pre;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (r_pre == PW'(PRESCALE - 1)) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    assign w_tick = (r_pre == PW'(PRESCALE - 1));
`else
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_cfg_wr = '0;
        w_clr    = '0;
        w_expire = '0;
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            w_cfg_wr[i] = w_wvalid && (32'(w_wch) == i) && (w_wreg == REG_TCFG);
            w_clr[i]    = w_wvalid && (32'(w_wch) == i) && (w_wreg == REG_TICLR) && bus.wdata[0];
            w_expire[i] = r_run[i] && w_tick && (r_tval[i] == '0);
        end
    end

    // Expiry is judged on pre-edge state, so it still sets pend when a TCFG write
    // lands in the same cycle, and it dominates a same-cycle TICLR.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                r_tcfg[i] <= '0;
                r_tval[i] <= '0;
            end
            r_run  <= '0;
            r_pend <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                if (w_cfg_wr[i]) begin
                    r_tcfg[i] <= bus.wdata;
                    r_tval[i] <= {bus.wdata[TW-1:2], 2'b00};
                    r_run[i]  <= bus.wdata[0];
                end else if (r_run[i] && w_tick) begin
                    if (r_tval[i] != '0) begin
                        r_tval[i] <= r_tval[i] - TW'(1);
                    end else if (r_tcfg[i][1]) begin
                        r_tval[i] <= {r_tcfg[i][TW-1:2], 2'b00};
                    end else begin
                        r_run[i] <= 1'b0;
                    end
                end

                if (w_expire[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
        end else begin
            r_stable <= r_stable + CNT_W'(1);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rvalid) begin
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                if (32'(w_rch) == i) begin
                    case (w_rreg)
                        REG_TCFG:   w_rdata = r_tcfg[i];
                        REG_TVAL:   w_rdata = r_tval[i];
                        REG_STATUS: w_rdata = TW'({r_pend[i], r_run[i]});
                        default:    w_rdata = '0;
                    endcase
                end
            end
        end
    end

    assign bus.rdata      = w_rdata;
    assign bus.pending    = r_pend;
    assign bus.irq_out    = (|(r_pend & bus.irq_mask)) & bus.ie;
    assign bus.stable_cnt = r_stable;
endmodule

// File: tb/tb_csr_timer_array.sv
// Self-checking bench for csr_timer_array (default build, no prescale): vector table,
// directed multi-cycle sequences and a randomized run against a behavioural model.
module tb_csr_timer_array;
    localparam int unsigned NT = 4;
    localparam int unsigned TW = 32;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    csr_timer_array_if #(.NUM_TIMERS(NT), .TW(TW), .CNT_W(CW)) bus_if ();

    csr_timer_array #(
        .NUM_TIMERS(NT),
        .TW        (TW),
        .CNT_W     (CW),
        .PRESCALE  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Behavioural reference: per-channel config word, remaining count, running and pending flags.
    logic [31:0] m_cfg  [NT];
    int unsigned m_tval [NT];
    bit          m_run  [NT];
    bit          m_pend [NT];
    int unsigned m_stable;

    task automatic model_edge();
        int unsigned ch;
        int unsigned rg;
        bit          hit;
        if (rst) begin
            for (int c = 0; c < NT; c++) begin
                m_cfg[c]  = '0;
                m_tval[c] = 0;
                m_run[c]  = 0;
                m_pend[c] = 0;
            end
            m_stable = 0;
        end else begin
            ch  = bus_if.waddr / 4;
            rg  = bus_if.waddr % 4;
            hit = bus_if.wen && (ch < NT);
            for (int c = 0; c < NT; c++) begin
                bit expire;
                expire = m_run[c] && (m_tval[c] == 0);
                if (expire) m_pend[c] = 1;
                else if (hit && ch == c && rg == 2 && bus_if.wdata[0]) m_pend[c] = 0;
                if (hit && ch == c && rg == 0) begin
                    m_cfg[c]  = bus_if.wdata;
                    m_tval[c] = bus_if.wdata & 32'hFFFF_FFFC;
                    m_run[c]  = bus_if.wdata[0];
                end else if (m_run[c]) begin
                    if (m_tval[c] > 0) m_tval[c] = m_tval[c] - 1;
                    else if (m_cfg[c][1]) m_tval[c] = m_cfg[c] & 32'hFFFF_FFFC;
                    else m_run[c] = 0;
                end
            end
            m_stable = (m_stable + 1) % (2 ** CW);
        end
    endtask

    function automatic logic [31:0] m_read(logic [7:0] a);
        int unsigned c;
        c = a / 4;
        if (c >= NT) return 32'h0;
        case (a % 4)
            0:       return m_cfg[c];
            1:       return m_tval[c];
            3:       return {30'b0, m_pend[c], m_run[c]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [NT-1:0] m_pendv();
        logic [NT-1:0] v;
        for (int c = 0; c < NT; c++) v[c] = m_pend[c];
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(string nm);
        chk({nm, ".rdata"}, 64'(bus_if.rdata), 64'(m_read(bus_if.raddr)));
        chk({nm, ".pending"}, 64'(bus_if.pending), 64'(m_pendv()));
        chk({nm, ".irq"}, 64'(bus_if.irq_out), 64'((|(m_pendv() & bus_if.irq_mask)) & bus_if.ie));
        chk({nm, ".stable"}, 64'(bus_if.stable_cnt), 64'(m_stable));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(logic [7:0] a, logic [31:0] d);
        bus_if.wen   = 1'b1;
        bus_if.waddr = a;
        bus_if.wdata = d;
        step();
        bus_if.wen   = 1'b0;
    endtask

    task automatic rd(logic [7:0] a);
        bus_if.raddr = a;
        #1;
    endtask

    typedef struct {
        bit          wen;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{1'b1, 8'h00, 32'h1234_5678, 8'h00, 32'h1234_5678};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,         8'h01, 32'h1234_5678};
        vecs[2]  = '{1'b1, 8'h14, 32'hFFFF_FFFF, 8'h14, 32'h0};
        vecs[3]  = '{1'b0, 8'h00, 32'h0,         8'h15, 32'h0};
        vecs[4]  = '{1'b1, 8'h09, 32'h0000_FFFF, 8'h09, 32'h0};
        vecs[5]  = '{1'b1, 8'h0B, 32'h0000_0003, 8'h0B, 32'h0};
        vecs[6]  = '{1'b1, 8'h0C, 32'hABCD_0002, 8'h0C, 32'hABCD_0002};
        vecs[7]  = '{1'b0, 8'h00, 32'h0,         8'h0E, 32'h0};
        vecs[8]  = '{1'b0, 8'h00, 32'h0,         8'h0F, 32'h0};
        vecs[9]  = '{1'b1, 8'h04, 32'h0000_1001, 8'h05, 32'h0000_1000};
        vecs[10] = '{1'b0, 8'h00, 32'h0,         8'h07, 32'h0000_0001};
        vecs[11] = '{1'b0, 8'h00, 32'h0,         8'h05, 32'h0000_0FFE};
        vecs[12] = '{1'b1, 8'h04, 32'h0,         8'h07, 32'h0};
        vecs[13] = '{1'b1, 8'h00, 32'h0,         8'h01, 32'h0};
        vecs[14] = '{1'b1, 8'h0C, 32'h0,         8'h0C, 32'h0};
        vecs[15] = '{1'b1, 8'hFC, 32'h0000_0001, 8'hFC, 32'h0};

        bus_if.wen      = 1'b0;
        bus_if.waddr    = '0;
        bus_if.wdata    = '0;
        bus_if.raddr    = '0;
        bus_if.irq_mask = '1;
        bus_if.ie       = 1'b1;
        rst             = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst.stable", 64'(bus_if.stable_cnt), 64'h0);
        chk("rst.pending", 64'(bus_if.pending), 64'h0);
        chk("rst.irq", 64'(bus_if.irq_out), 64'h0);
        repeat (5) step();
        chk("stable5", 64'(bus_if.stable_cnt), 64'd5);
        for (int a = 0; a < 24; a++) begin
            rd(8'(a));
            chk($sformatf("rst.rd%0d", a), 64'(bus_if.rdata), 64'h0);
            step();
        end
        bus_if.irq_mask = '0;
        bus_if.ie       = 1'b0;

        // Register-map vectors
        for (int i = 0; i < 16; i++) begin
            bus_if.wen   = vecs[i].wen;
            bus_if.waddr = vecs[i].waddr;
            bus_if.wdata = vecs[i].wdata;
            step();
            bus_if.wen = 1'b0;
            rd(vecs[i].raddr);
            chk($sformatf("vec%0d", i), 64'(bus_if.rdata), 64'(vecs[i].exp));
        end

        // One-shot ch1, InitVal=4
        bus_if.irq_mask = 4'b0010;
        bus_if.ie       = 1'b1;
        wr(8'h04, 32'h11);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("oneshot.early%0d", k), 64'(bus_if.pending[1]), 64'h0);
        end
        rd(8'h05);
        chk("oneshot.tval0", 64'(bus_if.rdata), 64'h0);
        step();
        chk("oneshot.pend", 64'(bus_if.pending[1]), 64'h1);
        chk("oneshot.irq", 64'(bus_if.irq_out), 64'h1);
        rd(8'h07);
        chk("oneshot.status", 64'(bus_if.rdata), 64'h2);
        wr(8'h06, 32'h1);
        chk("oneshot.clr.pend", 64'(bus_if.pending[1]), 64'h0);
        chk("oneshot.clr.irq", 64'(bus_if.irq_out), 64'h0);

        // Periodic ch0, tval=4, period 5
        bus_if.irq_mask = 4'b0001;
        wr(8'h00, 32'h7);
        repeat (4) step();
        chk("periodic.pre", 64'(bus_if.pending[0]), 64'h0);
        step();
        chk("periodic.exp1", 64'(bus_if.pending[0]), 64'h1);
        wr(8'h02, 32'h1);
        chk("periodic.clr", 64'(bus_if.pending[0]), 64'h0);
        repeat (3) step();
        chk("periodic.pre2", 64'(bus_if.pending[0]), 64'h0);
        wr(8'h02, 32'h1);
        chk("periodic.clr_vs_expiry", 64'(bus_if.pending[0]), 64'h1);
        bus_if.ie = 1'b0;
        #1;
        chk("ie0.irq", 64'(bus_if.irq_out), 64'h0);
        bus_if.ie = 1'b1;
        #1;
        chk("ie1.irq", 64'(bus_if.irq_out), 64'h1);
        wr(8'h00, 32'h0);
        wr(8'h02, 32'h1);
        chk("periodic.stop", 64'(bus_if.pending), 64'h0);

        // Independent channels 2 and 3
        wr(8'h08, 32'h09);
        wr(8'h0C, 32'h0D);
        for (int k = 0; k < 14; k++) begin
            step();
            rd(8'(8 + (k % 8)));
            cmp_model($sformatf("indep%0d", k));
        end
        chk("indep.pending", 64'(bus_if.pending), 64'hC);
        bus_if.irq_mask = 4'b1100;
        bus_if.ie       = 1'b0;
        #1;
        chk("indep.ie0", 64'(bus_if.irq_out), 64'h0);
        wr(8'h0A, 32'h1);
        wr(8'h0E, 32'h1);
        chk("indep.clr", 64'(bus_if.pending), 64'h0);

        // Mid-count TCFG rewrite and En=0 freeze
        wr(8'h08, 32'h21);
        repeat (5) step();
        rd(8'h09);
        chk("rewrite.before", 64'(bus_if.rdata), 64'd27);
        wr(8'h08, 32'h09);
        rd(8'h09);
        chk("rewrite.reload", 64'(bus_if.rdata), 64'd8);
        repeat (3) step();
        rd(8'h09);
        chk("rewrite.count", 64'(bus_if.rdata), 64'd5);
        wr(8'h08, 32'h40);
        repeat (10) step();
        rd(8'h09);
        chk("freeze.tval", 64'(bus_if.rdata), 64'h40);
        rd(8'h0B);
        chk("freeze.status", 64'(bus_if.rdata), 64'h0);

        // Reset mid-count overrides a same-edge write
        wr(8'h0C, 32'h3F);
        repeat (3) step();
        rst          = 1'b1;
        bus_if.wen   = 1'b1;
        bus_if.waddr = 8'h00;
        bus_if.wdata = 32'h5;
        step();
        rst        = 1'b0;
        bus_if.wen = 1'b0;
        rd(8'h0D);
        chk("midrst.tval3", 64'(bus_if.rdata), 64'h0);
        rd(8'h08);
        chk("midrst.tcfg2", 64'(bus_if.rdata), 64'h0);
        rd(8'h00);
        chk("midrst.tcfg0", 64'(bus_if.rdata), 64'h0);
        chk("midrst.stable", 64'(bus_if.stable_cnt), 64'h0);

        // InitVal=0 expires on the first edge after the write
        wr(8'h00, 32'h1);
        step();
        chk("init0.pend", 64'(bus_if.pending[0]), 64'h1);
        rd(8'h03);
        chk("init0.status", 64'(bus_if.rdata), 64'h2);
        wr(8'h02, 32'h1);

        // Stable counter wrap at CNT_W=8
        for (int k = 0; k < 300 && m_stable != 32'hFE; k++) step();
        step();
        chk("wrap.ff", 64'(bus_if.stable_cnt), 64'hFF);
        step();
        chk("wrap.00", 64'(bus_if.stable_cnt), 64'h00);

        // Randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            int unsigned rg;
            rg = $urandom_range(0, 3);
            bus_if.wen   = ($urandom_range(0, 2) == 0);
            bus_if.waddr = 8'($urandom_range(0, 7) * 4 + rg);
            if (rg == 0) bus_if.wdata = 32'(($urandom_range(0, 10) << 2) | $urandom_range(0, 3));
            else bus_if.wdata = $urandom;
            bus_if.irq_mask = 4'($urandom);
            bus_if.ie       = 1'($urandom_range(0, 1));
            step();
            bus_if.wen = 1'b0;
            if ($urandom_range(0, 15) == 0) rd(8'hFF);
            else rd(8'($urandom_range(0, 31)));
            cmp_model($sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
